// File: rtl/cache_l2_nway_pkg.sv
// Shared types for the N-way L2 cache: controller state encoding and line geometry.
package cache_l2_types;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WB    = 2'd2,
    FILL  = 2'd3
  } state_e;

endpackage

// File: rtl/cache_l2_plru.sv
// Tree pseudo-LRU bookkeeping: WAYS-1 bits per set, heap-ordered (node n -> children 2n, 2n+1).
module cache_l2_plru #(
  parameter int WAYS = 4,
  parameter int SETS = 32,
  localparam int WAY_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WAY_W-1:0] acc_way,
  input  logic             upd,
  output logic [WAY_W-1:0] victim
);

  // bit 0 of each set is unused so node numbers index directly
  logic [SETS-1:0][WAYS-1:0] tree_q;
  logic [WAYS-1:0]           cur, nxt;
  logic [WAY_W-1:0]          node_v, node_u;

  always_comb begin
    cur    = tree_q[set_idx];
    nxt    = cur;
    victim = '0;
    node_v = WAY_W'(1);
    node_u = WAY_W'(1);
    for (int l = 0; l < WAY_W; l++) begin
      victim[WAY_W-1-l] = cur[node_v];
      // a set bit means the victim lies in the upper half; point away from the access
      nxt[node_u] = ~acc_way[WAY_W-1-l];
      node_v = WAY_W'({node_v, cur[node_v]});
      node_u = WAY_W'({node_u, acc_way[WAY_W-1-l]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      tree_q <= '0;
    else if (upd) tree_q[set_idx] <= nxt;
  end

endmodule

// File: rtl/cache_l2_nway.sv
// N-way set-associative write-back/write-allocate L2 with tree-PLRU replacement.
// Define CACHE_L2_PERF_EN to add saturating hit/miss/write-back counters.
module cache_l2_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
`ifdef CACHE_L2_PERF_EN
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses,
  output logic [31:0]       perf_wbs,
`endif
  input  logic [LINE_W-1:0] pmem_rdata
);
  import cache_l2_types::*;

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = 32 - OFFSET_W - IDX_W;

  state_e                       state_q;
  logic [IDX_W-1:0]             idx;
  logic [TAG_W-1:0]             tag;
  logic [WAYS-1:0]              hit_vec, vld_vec, dty_vec;
  logic [WAYS-1:0][TAG_W-1:0]   tag_rd;
  logic [WAYS-1:0][LINE_W-1:0]  line_rd;
  logic [WAY_W-1:0]             hit_way, plru_way, vic_sel, vic_q;
  logic                         hit, first_q;
  logic                         chk_hit, wr_hit, wb_done, fill_done;
  logic                         unused_offset;

  assign idx           = mem_address[OFFSET_W +: IDX_W];
  assign tag           = mem_address[31 -: TAG_W];
  assign unused_offset = ^mem_address[OFFSET_W-1:0];

  assign hit       = |hit_vec;
  assign chk_hit   = (state_q == CHECK) && hit;
  assign wr_hit    = chk_hit && mem_write;
  assign wb_done   = (state_q == WB) && pmem_resp;
  assign fill_done = (state_q == FILL) && pmem_resp;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [LINE_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [SETS-1:0]   valid_q, dirty_q;
    logic              fill_me, wb_me, wr_me;

    assign fill_me = fill_done && (vic_q == WAY_W'(w));
    assign wb_me   = wb_done && (vic_q == WAY_W'(w));
    assign wr_me   = wr_hit && hit_vec[w];

    always_ff @(posedge clk) begin
      if (fill_me) begin
        data_q[idx] <= pmem_rdata;
        tag_q[idx]  <= tag;
      end else if (wr_me) begin
        data_q[idx] <= mem_wdata;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        dirty_q <= '0;
      end else begin
        if (fill_me) begin
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
        end
        if (wb_me) dirty_q[idx] <= 1'b0;
        if (wr_me) dirty_q[idx] <= 1'b1;
      end
    end

    assign tag_rd[w]  = tag_q[idx];
    assign line_rd[w] = data_q[idx];
    assign vld_vec[w] = valid_q[idx];
    assign dty_vec[w] = dirty_q[idx];
    assign hit_vec[w] = valid_q[idx] && (tag_q[idx] == tag);
  end

  always_comb begin
    hit_way = '0;
    vic_sel = plru_way;
    // walk downward so the lowest invalid way wins over the PLRU choice
    for (int w = WAYS - 1; w >= 0; w--)
      if (!vld_vec[w]) vic_sel = WAY_W'(w);
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  cache_l2_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk     (clk),
    .rst     (rst),
    .set_idx (idx),
    .acc_way (hit_way),
    .upd     (chk_hit),
    .victim  (plru_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
      vic_q     <= '0;
      first_q   <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      case (state_q)
        IDLE: begin
          // mem_resp high means the requester has not yet dropped the finished request
          if ((mem_read || mem_write) && !mem_resp) begin
            state_q <= CHECK;
            first_q <= 1'b1;
          end
        end
        CHECK: begin
          first_q <= 1'b0;
          if (hit) begin
            mem_resp <= 1'b1;
            if (!mem_write) mem_rdata <= line_rd[hit_way];
            state_q <= IDLE;
          end else begin
            vic_q   <= vic_sel;
            state_q <= (vld_vec[vic_sel] && dty_vec[vic_sel]) ? WB : FILL;
          end
        end
        WB:      if (pmem_resp) state_q <= FILL;
        FILL:    if (pmem_resp) state_q <= CHECK;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    pmem_read    = (state_q == FILL);
    pmem_write   = (state_q == WB);
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state_q == WB) begin
      pmem_address = {tag_rd[vic_q], idx, {OFFSET_W{1'b0}}};
      pmem_wdata   = line_rd[vic_q];
    end else if (state_q == FILL) begin
      pmem_address = {tag, idx, {OFFSET_W{1'b0}}};
    end
  end

`ifdef CACHE_L2_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
      perf_wbs    <= '0;
    end else begin
      if (chk_hit && perf_hits != 32'hFFFF_FFFF)
        perf_hits <= perf_hits + 32'd1;
      if ((state_q == CHECK) && !hit && first_q && perf_misses != 32'hFFFF_FFFF)
        perf_misses <= perf_misses + 32'd1;
      if (wb_done && perf_wbs != 32'hFFFF_FFFF)
        perf_wbs <= perf_wbs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_l2_nway.sv
// Randomized scoreboard bench for cache_l2_nway against a flat-memory + set/way reference model.
module tb_cache_l2_nway;
  localparam int WAYS = 4;
  localparam int SETS = 32;

  logic         clk, rst;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [255:0] mem_wdata, mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
`ifdef CACHE_L2_PERF_EN
  logic [31:0]  perf_hits, perf_misses, perf_wbs;
`endif

  cache_l2_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
`ifdef CACHE_L2_PERF_EN
    .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbs(perf_wbs),
`endif
    .pmem_rdata(pmem_rdata)
  );

  typedef struct { bit rd; logic [255:0] data; bit hit; int t; } exp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } pexp_t;

  exp_t  exp_q[$];
  pexp_t pexp_q[$];

  int n_cmp = 0, n_err = 0, cyc = 0, wb1000 = 0;
  int n_hit = 0, n_miss = 0, n_wb = 0;

  // reference model: flat memories plus per-set residency and tree-PLRU bits
  logic [255:0] gold [int];
  logic [255:0] pm   [int];
  bit           m_vld [SETS][WAYS];
  bit           m_dty [SETS][WAYS];
  int           m_tag [SETS][WAYS];
  logic [255:0] m_line[SETS][WAYS];
  bit           pl    [SETS][WAYS];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input int la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = (la * 32'h9E37_79B1) ^ (k << 28) ^ 32'h5A00_0000;
    return l;
  endfunction

  function automatic logic [255:0] get_gold(input int la);
    return gold.exists(la) ? gold[la] : init_line(la);
  endfunction

  function automatic logic [255:0] get_pm(input int la);
    return pm.exists(la) ? pm[la] : init_line(la);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // descend by halving the way range; each node bit says which half holds the victim
  function automatic int m_victim(input int s);
    int lo = 0, hi = WAYS, node = 1, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (pl[s][node]) begin lo = mid; node = 2 * node + 1; end
      else             begin hi = mid; node = 2 * node;     end
    end
    return lo;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int lo = 0, hi = WAYS, node = 1, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin pl[s][node] = 1'b1; hi = mid; node = 2 * node;     end
      else         begin pl[s][node] = 1'b0; lo = mid; node = 2 * node + 1; end
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_vld[s][w] = 0; m_dty[s][w] = 0; pl[s][w] = 0;
      end
    exp_q.delete();
    pexp_q.delete();
    gold.delete();
    foreach (pm[k]) gold[k] = pm[k];
    n_hit = 0; n_miss = 0; n_wb = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    rst = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] addr, input bit wr, input logic [255:0] wd);
    int s, t, la, hw, v;
    bit got, hit;
    exp_t e;
    la = int'(addr >> 5);
    s  = la % SETS;
    t  = int'(addr >> 10);
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (m_vld[s][w] && m_tag[s][w] == t) hw = w;
    hit = (hw >= 0);
    if (!hit) begin
      n_miss++;
      v = -1;
      for (int w = 0; w < WAYS; w++) if (v < 0 && !m_vld[s][w]) v = w;
      if (v < 0) v = m_victim(s);
      if (m_vld[s][v] && m_dty[s][v]) begin
        pexp_q.push_back('{1'b1, 32'((m_tag[s][v] << 10) | (s << 5)), m_line[s][v]});
        n_wb++;
      end
      pexp_q.push_back('{1'b0, 32'(la << 5), '0});
      m_vld[s][v] = 1; m_dty[s][v] = 0; m_tag[s][v] = t; m_line[s][v] = get_gold(la);
      hw = v;
    end
    n_hit++;
    m_touch(s, hw);
    if (wr) begin
      m_line[s][hw] = wd; m_dty[s][hw] = 1; gold[la] = wd;
    end
    @(negedge clk);
    e.rd = !wr; e.data = m_line[s][hw]; e.hit = hit; e.t = cyc;
    exp_q.push_back(e);
    mem_address = addr;
    mem_write   = wr;
    mem_read    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_wdata   = wr ? wd : rnd_line();
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_resp) begin got = 1; break; end
    end
    chk("resp_seen", got, 1);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // monitor: scoreboard pop on every mem_resp
  always @(negedge clk) begin
    exp_t e;
    int lat;
    if (!rst && mem_resp) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL resp_unexpected: got mem_resp=1 expected no response");
      end else begin
        e = exp_q.pop_front();
        lat = cyc - e.t;
        if (e.rd) chk("rdata", mem_rdata, e.data);
        if (e.hit) chk("hit_latency", 256'(lat), 256'd2);
        else       chk("miss_latency_ge4", 256'(lat >= 4), 256'd1);
      end
    end
  end

  // physical memory: checks each new request against expectations, answers after 1..4 cycles
  initial begin
    pexp_t pe;
    int d, la;
    bit ab;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (!rst && (pmem_read || pmem_write)) begin
        if (pexp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL pmem_unexpected: got rd=%0b wr=%0b addr %0h expected none",
                   pmem_read, pmem_write, pmem_address);
        end else begin
          pe = pexp_q.pop_front();
          chk("pmem_dir", {pmem_write, pmem_read}, pe.wr ? 2'b10 : 2'b01);
          chk("pmem_addr", pmem_address, pe.addr);
          if (pe.wr) chk("pmem_wdata", pmem_wdata, pe.data);
        end
        if (pmem_write && pmem_address == 32'h1000 && pmem_wdata == {32{8'hA5}}) wb1000++;
        d = $urandom_range(0, 3); ab = 0;
        for (int k = 0; k < d; k++) begin
          @(negedge clk);
          if (rst) begin ab = 1; break; end
        end
        if (!ab && !rst) begin
          la = int'(pmem_address >> 5);
          if (pmem_write) pm[la] = pmem_wdata;
          else            pmem_rdata = get_pm(la);
          pmem_resp = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    bit got;
    int seq4[10] = '{10, 11, 12, 13, 10, 14, 10, 11, 13, 12};
    rst = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_resp",   mem_resp, 0);
    chk("rst_pmem_read",  pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr",  pmem_address, 0);
    chk("rst_mem_rdata",  mem_rdata, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    rst = 1'b0;

    // cold miss then hit on the same line
    do_req(32'h0000_1000, 0, '0);
    do_req(32'h0000_1000, 0, '0);
    // dirty line is evicted exactly once by WAYS+1 conflicting tags
    do_req(32'h0000_1000, 1, {32{8'hA5}});
    for (int k = 1; k <= WAYS + 1; k++) do_req(32'((4 + k) << 10), 0, '0);
    chk("wb_1000_count", 256'(wb1000), 256'd1);

    // PLRU sequence in set 3
    do_reset();
    foreach (seq4[i]) do_req(32'((seq4[i] << 10) | (3 << 5)), 0, '0);

    // reset in the middle of a fill
    do_reset();
    @(negedge clk);
    pexp_q.push_back('{1'b0, 32'h0000_2000, '0});
    mem_address = 32'h0000_2000; mem_read = 1'b1;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pmem_read) begin got = 1; break; end
    end
    chk("fill_started", got, 1);
    rst = 1'b1;
    #1;
    chk("midfill_pmem_read", pmem_read, 0);
    chk("midfill_pmem_addr", pmem_address, 0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    rst = 1'b0;
    do_req(32'h0000_2000, 0, '0);

    // random traffic over a few conflicting tags
    repeat (300) begin
      a = 32'(($urandom_range(0, 7) << 10) | ($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) do_req(a, 1, rnd_line());
      else                           do_req(a, 0, '0);
    end

    repeat (5) @(negedge clk);
`ifdef CACHE_L2_PERF_EN
    chk("perf_hits",   perf_hits,   256'(n_hit));
    chk("perf_misses", perf_misses, 256'(n_miss));
    chk("perf_wbs",    perf_wbs,    256'(n_wb));
`endif
    chk("exp_q_drained",  256'(exp_q.size()),  256'd0);
    chk("pexp_q_drained", 256'(pexp_q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
